irq_pending_sequencer: RTL and testbench

- Sequential front/back wrapper for the 9-channel, 3-bus priority interrupt decoder netlist.
- Upstream: captures request pulses into per-bus pending registers that drive the decoder's request inputs.
- Downstream: waits for the decoder's combinational outputs to settle, registers the winning bus/channel, and presents it on a valid/ready handshake.
- Clears the serviced pending bit on acknowledge. Sits between peripheral request lines and the CPU interrupt port.

---
 rtl/irq_seq_pkg.sv | 31 +++
 rtl/irq_pend_bank.sv | 44 ++++
 rtl/irq_pending_sequencer.sv | 154 +++++++++++++++
 tb/tb_irq_pending_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_seq_pkg.sv
// Shared types and constants for the interrupt pending sequencer.
// Pure declarations: no latency, no flow control.
// The decoder's bus flag vector is ordered {A,B,C} with A in the MSB.
package irq_seq_pkg;

    localparam int NCH_DEF = 9;
    localparam int CW_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_CLEAR   = 2'd3
    } irq_state_t;

    localparam logic [1:0] BUS_A = 2'd0;
    localparam logic [1:0] BUS_B = 2'd1;
    localparam logic [1:0] BUS_C = 2'd2;

    localparam int DEC_A_BIT = 2;
    localparam int DEC_B_BIT = 1;
    localparam int DEC_C_BIT = 0;

    // Fixed A > B > C priority when the decoder raises more than one flag.
    function automatic logic [1:0] dec_pick(input logic [2:0] flags);
        if (flags[DEC_A_BIT])      return BUS_A;
        else if (flags[DEC_B_BIT]) return BUS_B;
        else                       return BUS_C;
    endfunction

endpackage

// File: rtl/irq_pend_bank.sv
// Per-bus pending register: request pulses set bits, one indexed bit may be cleared.
// Latency: request visible on pend_o one cycle later; chg_o flags a pend_o edge.
// No backpressure: requests are always accepted, and a set beats a same-cycle clear.
module irq_pend_bank
    import irq_seq_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req_i,
    input  logic           clr_vld_i,
    input  logic [CW-1:0]  clr_idx_i,
    output logic [NCH-1:0] pend_o,
    output logic           chg_o
);

    logic [NCH-1:0] pend_q, pend_d, clr_mask;
    logic           chg_q;

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            clr_mask[i] = clr_vld_i && (clr_idx_i == CW'(i));
        end
        pend_d = (pend_q & ~clr_mask) | req_i;
    end

    // chg_q is high in the cycle whose pend_o differs from the cycle before.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            chg_q  <= (pend_d != pend_q);
        end
    end

    assign pend_o = pend_q;
    assign chg_o  = chg_q;

endmodule

// File: rtl/irq_pending_sequencer.sv
// Wraps the 3-bus priority decoder: pending capture, settle wait, valid/ready presentation.
// Latency: request pulse to irq_valid is SETTLE_CYC+2 cycles; optional IRQ_TIMEOUT_EN handshake timeout.
// Backpressure: irq_valid holds until irq_ready; requests keep accumulating meanwhile.
module irq_pending_sequencer
    import irq_seq_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int CW         = CW_DEF,
    parameter int SETTLE_CYC = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req_a,
    input  logic [NCH-1:0] req_b,
    input  logic [NCH-1:0] req_c,
    input  logic [NCH-1:0] chan_en,
    output logic [NCH-1:0] pend_a,
    output logic [NCH-1:0] pend_b,
    output logic [NCH-1:0] pend_c,
    output logic [NCH-1:0] en_q,
    input  logic [2:0]     dec_bus,
    input  logic [CW-1:0]  dec_chan,
    output logic           irq_valid,
    input  logic           irq_ready,
    output logic [1:0]     irq_bus,
    output logic [CW-1:0]  irq_chan,
    output logic           busy,
    output logic           irq_err
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

    irq_state_t     state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     bus_q, bus_d;
    logic [CW-1:0]  chan_q, chan_d;
    logic [NCH-1:0] en_r_q;
    logic           en_chg_q;
    logic           chg_a, chg_b, chg_c, any_chg, any_req, dec_ok, tmo_hit;
    logic           in_clear;

    assign in_clear = (state_q == ST_CLEAR);

    irq_pend_bank #(.NCH(NCH), .CW(CW)) u_bank_a (
        .clk(clk), .rst(rst), .req_i(req_a),
        .clr_vld_i(in_clear && (bus_q == BUS_A)), .clr_idx_i(chan_q),
        .pend_o(pend_a), .chg_o(chg_a)
    );

    irq_pend_bank #(.NCH(NCH), .CW(CW)) u_bank_b (
        .clk(clk), .rst(rst), .req_i(req_b),
        .clr_vld_i(in_clear && (bus_q == BUS_B)), .clr_idx_i(chan_q),
        .pend_o(pend_b), .chg_o(chg_b)
    );

    irq_pend_bank #(.NCH(NCH), .CW(CW)) u_bank_c (
        .clk(clk), .rst(rst), .req_i(req_c),
        .clr_vld_i(in_clear && (bus_q == BUS_C)), .clr_idx_i(chan_q),
        .pend_o(pend_c), .chg_o(chg_c)
    );

    assign any_req = |((pend_a | pend_b | pend_c) & en_r_q);
    assign any_chg = chg_a | chg_b | chg_c | en_chg_q;
    assign dec_ok  = (|dec_bus) && (dec_chan < CW'(NCH));

`ifdef IRQ_TIMEOUT_EN
    logic [7:0] tmo_q;
    logic       err_q;

    assign tmo_hit = (state_q == ST_PRESENT) && !irq_ready && (tmo_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == ST_PRESENT) ? tmo_q + 8'd1 : 8'd0;
            err_q <= err_q | tmo_hit;
        end
    end

    assign irq_err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT != 0);
    assign tmo_hit    = 1'b0;
    assign irq_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bus_q    <= '0;
            chan_q   <= '0;
            en_r_q   <= '0;
            en_chg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bus_q    <= bus_d;
            chan_q   <= chan_d;
            en_r_q   <= chan_en;
            en_chg_q <= (chan_en != en_r_q);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        chan_d  = chan_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LD;
                end
            end
            ST_SETTLE: begin
                // A moving decoder input restarts the wait even on the sampling cycle.
                if (any_chg) begin
                    cnt_d = SETTLE_LD;
                end else if (cnt_q == 4'd0) begin
                    if (dec_ok) begin
                        bus_d   = dec_pick(dec_bus);
                        chan_d  = dec_chan;
                        state_d = ST_PRESENT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_PRESENT: begin
                if (irq_ready)    state_d = ST_CLEAR;
                else if (tmo_hit) state_d = ST_IDLE;
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        irq_valid = (state_q == ST_PRESENT);
        busy      = (state_q != ST_IDLE);
        irq_bus   = bus_q;
        irq_chan  = chan_q;
        en_q      = en_r_q;
    end

endmodule

// File: tb/tb_irq_pending_sequencer.sv
// Self-checking bench for irq_pending_sequencer with a behavioural decoder model and scoreboard.
module tb_irq_pending_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] req_a, req_b, req_c, chan_en;
    logic [8:0] pend_a, pend_b, pend_c, en_q;
    logic [2:0] dec_bus;
    logic [3:0] dec_chan;
    logic       irq_valid, irq_ready, busy, irq_err;
    logic [1:0] irq_bus;
    logic [3:0] irq_chan;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_q[$];
    logic [5:0] obs_mem[0:63];
    int         obs_wr = 0;
    int         obs_rd = 0;
    logic       bad_chan = 1'b0;

    always #5 clk = ~clk;

    irq_pending_sequencer #(.NCH(9), .CW(4), .SETTLE_CYC(2), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .chan_en(chan_en),
        .pend_a(pend_a), .pend_b(pend_b), .pend_c(pend_c), .en_q(en_q),
        .dec_bus(dec_bus), .dec_chan(dec_chan),
        .irq_valid(irq_valid), .irq_ready(irq_ready),
        .irq_bus(irq_bus), .irq_chan(irq_chan),
        .busy(busy), .irq_err(irq_err)
    );

    // Decoder model: one flag per bus with enabled pending work, lowest channel of the top bus.
    always_comb begin
        logic [8:0] ma, mb, mc, sel;
        ma = pend_a & en_q;
        mb = pend_b & en_q;
        mc = pend_c & en_q;
        dec_bus  = {|ma, |mb, |mc};
        sel      = (ma != 0) ? ma : ((mb != 0) ? mb : mc);
        dec_chan = 4'd0;
        for (int i = 8; i >= 0; i--) if (sel[i]) dec_chan = 4'(i);
        if (bad_chan) dec_chan = 4'd12;
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && irq_valid && irq_ready) begin
            obs_mem[obs_wr[5:0]] <= {irq_bus, irq_chan};
            obs_wr <= obs_wr + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset;
        rst = 1'b1; req_a = '0; req_b = '0; req_c = '0; chan_en = 9'h1FF; irq_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pend_a, pend_b, pend_c, en_q} !== '0 || irq_valid !== 1'b0 || busy !== 1'b0 ||
            irq_err !== 1'b0 || irq_bus !== 2'd0 || irq_chan !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b err=%b bus=%0d chan=%0d en_q=%h, want all 0",
                     irq_valid, busy, irq_err, irq_bus, irq_chan, en_q);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (en_q !== 9'h1FF || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: en_q=%h busy=%b, want 1ff 0", en_q, busy);
        end
    endtask

    task automatic test_single;
        int cyc;
        logic [5:0] e, o;
        exp_q.push_back({2'd1, 4'd3});
        irq_ready = 1'b1;
        req_b[3] = 1'b1;
        @(posedge clk); #1 req_b = '0;
        checks++;
        if (pend_b[3] !== 1'b1) begin errors++; $display("FAIL single_pend_set: pend_b=%h, want bit3 set", pend_b); end
        cyc = 1;
        while (!irq_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (cyc != 4) begin errors++; $display("FAIL single_latency: valid after %0d cycles, want 4", cyc); end
        checks++;
        if (irq_bus !== 2'd1 || irq_chan !== 4'd3) begin
            errors++; $display("FAIL single_value: bus=%0d chan=%0d, want 1 3", irq_bus, irq_chan);
        end
        @(posedge clk); #1;
        checks++;
        if (irq_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_clear_cycle: valid=%b busy=%b, want 0 1", irq_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (pend_b[3] !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_pend_clr: pend_b=%h busy=%b, want 0 0", pend_b, busy);
        end
        cyc = 0;
        while ((obs_wr - obs_rd) < int'(exp_q.size()) && cyc < 300) begin @(posedge clk); #1; cyc++; end
        checks++;
        if ((obs_wr - obs_rd) != int'(exp_q.size())) begin
            errors++; $display("FAIL single_count: got %0d irqs, want %0d", obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[5:0]]; obs_rd++; checks++;
            if (o !== e) begin errors++; $display("FAIL single_sb: got %0d/%0d, want %0d/%0d", o[5:4], o[3:0], e[5:4], e[3:0]); end
        end
        exp_q.delete(); obs_rd = obs_wr;
    endtask

    task automatic test_priority;
        int cyc;
        logic [5:0] e, o;
        exp_q.push_back({2'd0, 4'd5});
        exp_q.push_back({2'd2, 4'd0});
        irq_ready = 1'b1;
        req_a[5] = 1'b1; req_c[0] = 1'b1;
        @(posedge clk); #1 req_a = '0; req_c = '0;
        cyc = 0;
        while (!irq_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (irq_valid !== 1'b1 || irq_bus !== 2'd0 || irq_chan !== 4'd5) begin
            errors++; $display("FAIL prio_first: valid=%b bus=%0d chan=%0d, want 1 0 5", irq_valid, irq_bus, irq_chan);
        end
        cyc = 0;
        while ((obs_wr - obs_rd) < int'(exp_q.size()) && cyc < 300) begin @(posedge clk); #1; cyc++; end
        checks++;
        if ((obs_wr - obs_rd) != int'(exp_q.size())) begin
            errors++; $display("FAIL prio_count: got %0d irqs, want %0d", obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[5:0]]; obs_rd++; checks++;
            if (o !== e) begin errors++; $display("FAIL prio_sb: got %0d/%0d, want %0d/%0d", o[5:4], o[3:0], e[5:4], e[3:0]); end
        end
        exp_q.delete(); obs_rd = obs_wr;
    endtask

    task automatic test_stall;
        int cyc;
        logic stable;
        logic [5:0] e, o;
        exp_q.push_back({2'd2, 4'd8});
        exp_q.push_back({2'd0, 4'd1});
        irq_ready = 1'b0;
        req_c[8] = 1'b1;
        @(posedge clk); #1 req_c = '0;
        cyc = 0;
        while (!irq_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 5) req_a[1] = 1'b1;
            if (i == 6) req_a = '0;
            if (irq_valid !== 1'b1 || irq_bus !== 2'd2 || irq_chan !== 4'd8) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++; $display("FAIL stall_hold: valid=%b bus=%0d chan=%0d, want steady 1 2 8", irq_valid, irq_bus, irq_chan);
        end
        checks++;
        if (pend_a[1] !== 1'b1) begin errors++; $display("FAIL stall_accum: pend_a=%h, want bit1 set", pend_a); end
        irq_ready = 1'b1;
        cyc = 0;
        while ((obs_wr - obs_rd) < int'(exp_q.size()) && cyc < 300) begin @(posedge clk); #1; cyc++; end
        checks++;
        if ((obs_wr - obs_rd) != int'(exp_q.size())) begin
            errors++; $display("FAIL stall_count: got %0d irqs, want %0d", obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[5:0]]; obs_rd++; checks++;
            if (o !== e) begin errors++; $display("FAIL stall_sb: got %0d/%0d, want %0d/%0d", o[5:4], o[3:0], e[5:4], e[3:0]); end
        end
        exp_q.delete(); obs_rd = obs_wr;
    endtask

    task automatic test_set_wins;
        int cyc;
        logic [5:0] e, o;
        exp_q.push_back({2'd2, 4'd7});
        exp_q.push_back({2'd2, 4'd7});
        irq_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        req_c[7] = 1'b1;
        @(posedge clk); #1 req_c = '0;
        cyc = 0;
        while (!irq_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        irq_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (irq_valid !== 1'b0) begin errors++; $display("FAIL setwin_valid_fall: valid=%b, want 0", irq_valid); end
        req_c[7] = 1'b1;
        @(posedge clk); #1 req_c = '0;
        checks++;
        if (pend_c[7] !== 1'b1) begin errors++; $display("FAIL setwin_pend: pend_c=%h, want bit7 set", pend_c); end
        cyc = 0;
        while ((obs_wr - obs_rd) < int'(exp_q.size()) && cyc < 300) begin @(posedge clk); #1; cyc++; end
        checks++;
        if ((obs_wr - obs_rd) != int'(exp_q.size())) begin
            errors++; $display("FAIL setwin_count: got %0d irqs, want %0d", obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[5:0]]; obs_rd++; checks++;
            if (o !== e) begin errors++; $display("FAIL setwin_sb: got %0d/%0d, want %0d/%0d", o[5:4], o[3:0], e[5:4], e[3:0]); end
        end
        exp_q.delete(); obs_rd = obs_wr;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (pend_c[7] !== 1'b0) begin errors++; $display("FAIL setwin_final_clr: pend_c=%h, want 0", pend_c); end
    endtask

    task automatic test_enable_gate;
        int cyc;
        logic saw;
        logic [5:0] e, o;
        irq_ready = 1'b1;
        chan_en[4] = 1'b0;
        repeat (2) @(posedge clk); #1;
        req_a[4] = 1'b1;
        @(posedge clk); #1 req_a = '0;
        saw = 1'b0;
        repeat (12) begin @(posedge clk); #1; saw = saw | irq_valid | busy; end
        checks++;
        if (saw !== 1'b0 || pend_a[4] !== 1'b1) begin
            errors++; $display("FAIL engate_masked: activity=%b pend_a=%h, want 0 and bit4 set", saw, pend_a);
        end
        exp_q.push_back({2'd0, 4'd4});
        chan_en = 9'h1FF;
        cyc = 0;
        while ((obs_wr - obs_rd) < int'(exp_q.size()) && cyc < 300) begin @(posedge clk); #1; cyc++; end
        checks++;
        if ((obs_wr - obs_rd) != int'(exp_q.size())) begin
            errors++; $display("FAIL engate_count: got %0d irqs, want %0d", obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[5:0]]; obs_rd++; checks++;
            if (o !== e) begin errors++; $display("FAIL engate_sb: got %0d/%0d, want %0d/%0d", o[5:4], o[3:0], e[5:4], e[3:0]); end
        end
        exp_q.delete(); obs_rd = obs_wr;
    endtask

    task automatic test_bad_decode;
        int cyc;
        logic saw_v, saw_b;
        logic [5:0] e, o;
        bad_chan = 1'b1;
        irq_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        req_b[0] = 1'b1;
        @(posedge clk); #1 req_b = '0;
        saw_v = 1'b0; saw_b = 1'b0;
        repeat (20) begin @(posedge clk); #1; saw_v = saw_v | irq_valid; saw_b = saw_b | busy; end
        checks++;
        if (saw_v !== 1'b0 || saw_b !== 1'b1) begin
            errors++; $display("FAIL baddec_reject: valid_seen=%b busy_seen=%b, want 0 1", saw_v, saw_b);
        end
        exp_q.push_back({2'd1, 4'd0});
        bad_chan = 1'b0;
        cyc = 0;
        while ((obs_wr - obs_rd) < int'(exp_q.size()) && cyc < 300) begin @(posedge clk); #1; cyc++; end
        checks++;
        if ((obs_wr - obs_rd) != int'(exp_q.size())) begin
            errors++; $display("FAIL baddec_count: got %0d irqs, want %0d", obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[5:0]]; obs_rd++; checks++;
            if (o !== e) begin errors++; $display("FAIL baddec_sb: got %0d/%0d, want %0d/%0d", o[5:4], o[3:0], e[5:4], e[3:0]); end
        end
        exp_q.delete(); obs_rd = obs_wr;
    endtask

    task automatic test_timeout;
        int cyc;
        int hi;
        logic [5:0] e, o;
        irq_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        req_a[2] = 1'b1;
        @(posedge clk); #1 req_a = '0;
        cyc = 0;
        while (!irq_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        hi = 0;
        while (irq_valid && hi < 40) begin @(posedge clk); #1; hi++; end
`ifdef IRQ_TIMEOUT_EN
        checks++;
        if (hi != 10 || irq_err !== 1'b1 || pend_a[2] !== 1'b1) begin
            errors++; $display("FAIL tmo_drop: valid_cycles=%0d err=%b pend_a=%h, want 10 1 bit2", hi, irq_err, pend_a);
        end
        cyc = 0;
        while (!irq_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (irq_valid !== 1'b1 || irq_bus !== 2'd0 || irq_chan !== 4'd2) begin
            errors++; $display("FAIL tmo_represent: valid=%b bus=%0d chan=%0d, want 1 0 2", irq_valid, irq_bus, irq_chan);
        end
`else
        checks++;
        if (hi != 40 || irq_err !== 1'b0) begin
            errors++; $display("FAIL notmo_hold: valid_cycles=%0d err=%b, want 40 0", hi, irq_err);
        end
`endif
        exp_q.push_back({2'd0, 4'd2});
        irq_ready = 1'b1;
        cyc = 0;
        while ((obs_wr - obs_rd) < int'(exp_q.size()) && cyc < 300) begin @(posedge clk); #1; cyc++; end
        checks++;
        if ((obs_wr - obs_rd) != int'(exp_q.size())) begin
            errors++; $display("FAIL tmo_count: got %0d irqs, want %0d", obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[5:0]]; obs_rd++; checks++;
            if (o !== e) begin errors++; $display("FAIL tmo_sb: got %0d/%0d, want %0d/%0d", o[5:4], o[3:0], e[5:4], e[3:0]); end
        end
        exp_q.delete(); obs_rd = obs_wr;
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic saw;
        irq_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        req_b[8] = 1'b1;
        @(posedge clk); #1 req_b = '0;
        cyc = 0;
        while (!irq_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        req_c[1] = 1'b1;
        @(posedge clk); #1 req_c = '0;
        checks++;
        if (irq_valid !== 1'b1 || pend_c[1] !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: valid=%b pend_c=%h, want 1 bit1", irq_valid, pend_c);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (irq_valid !== 1'b0 || busy !== 1'b0 || {pend_a, pend_b, pend_c} !== '0 ||
            en_q !== '0 || irq_err !== 1'b0 || irq_bus !== 2'd0 || irq_chan !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b busy=%b pend=%h/%h/%h err=%b bus=%0d chan=%0d, want all 0",
                     irq_valid, busy, pend_a, pend_b, pend_c, irq_err, irq_bus, irq_chan);
        end
        repeat (2) @(posedge clk); #1 rst = 1'b0;
        saw = 1'b0;
        repeat (10) begin @(posedge clk); #1; saw = saw | irq_valid | busy | (|pend_b) | (|pend_c); end
        checks++;
        if (saw !== 1'b0) begin errors++; $display("FAIL rstmid_lost: activity after reset=%b, want 0", saw); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_stall();
        test_set_wins();
        test_enable_gate();
        test_bad_decode();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
